// File: rtl/raster_walker.sv
// Bounding-box raster walker: steps every pixel centre of a clamped box, evaluates three
// edge functions incrementally and emits covered pixels over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a triangle, tri_ready high
// INIT  | evaluate edges at the first pixel centre of the box
// WALK  | test one pixel per advance, step cursor in raster order
// DONE  | drain the last fragment, pulse tri_done
module raster_walker #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tri_valid,
    output logic         tri_ready,
    input  logic [144:0] tri_e0,
    input  logic [144:0] tri_e1,
    input  logic [144:0] tri_e2,
    input  logic [11:0]  tri_min_x,
    input  logic [11:0]  tri_min_y,
    input  logic [11:0]  tri_max_x,
    input  logic [11:0]  tri_max_y,
    input  logic         tri_en,
    output logic         frag_valid,
    input  logic         frag_ready,
    output logic [11:0]  frag_x,
    output logic [11:0]  frag_y,
    output logic         busy,
    output logic         tri_done
);
    typedef enum logic [1:0] {IDLE, INIT, WALK, DONE} state_t;

    localparam logic [11:0] X_LIM = 12'(SCREEN_W - 1);
    localparam logic [11:0] Y_LIM = 12'(SCREEN_H - 1);

    state_t state, state_nx;

    logic [144:0]       tri_e  [3];
    logic signed [47:0] ea     [3];
    logic signed [47:0] eb     [3];
    logic signed [47:0] ec     [3];
    logic signed [47:0] e_row  [3];
    logic signed [47:0] e_cur  [3];
    logic signed [47:0] e_init [3];
    logic [2:0]         etl;
    logic [11:0]        min_x, min_y, max_x, max_y, cur_x, cur_y;
    logic [11:0]        clamp_x, clamp_y;
    logic               empty, advance, covered, last_px, drained;

    assign tri_e[0] = tri_e0;
    assign tri_e[1] = tri_e1;
    assign tri_e[2] = tri_e2;

    // Coefficient (S31.16) times pixel centre (coord + 0.5 as S15.16), rescaled to S31.16.
    function automatic logic signed [47:0] mul_fx(logic signed [47:0] k, logic [11:0] coord);
        logic signed [95:0] p;
        p = 96'(k) * 96'(signed'({4'b0000, coord, 16'h8000}));
        return 48'(p >>> 16);
    endfunction

    always_comb begin
        clamp_x = (tri_max_x > X_LIM) ? X_LIM : tri_max_x;
        clamp_y = (tri_max_y > Y_LIM) ? Y_LIM : tri_max_y;
        empty   = !tri_en || (tri_min_x > clamp_x) || (tri_min_y > clamp_y);
        drained = !frag_valid || frag_ready;
        advance = (state == WALK) && drained;
        last_px = (cur_x >= max_x) && (cur_y >= max_y);
        covered = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e_init[i] = mul_fx(ea[i], min_x) + mul_fx(eb[i], min_y) + ec[i];
            if (!((e_cur[i] > 48'sd0) || ((e_cur[i] == 48'sd0) && etl[i])))
                covered = 1'b0;
        end
    end

    always_comb begin
        state_nx  = state;
        tri_ready = (state == IDLE);
        busy      = (state != IDLE);
        tri_done  = 1'b0;
        case (state)
            IDLE: if (tri_valid) state_nx = empty ? DONE : INIT;
            INIT: state_nx = WALK;
            WALK: if (advance && last_px) state_nx = DONE;
            DONE: begin
                if (drained) begin
                    tri_done = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                ea[i]    <= '0;
                eb[i]    <= '0;
                ec[i]    <= '0;
                e_row[i] <= '0;
                e_cur[i] <= '0;
            end
            etl        <= '0;
            min_x      <= '0;
            min_y      <= '0;
            max_x      <= '0;
            max_y      <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            frag_valid <= 1'b0;
            frag_x     <= '0;
            frag_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tri_valid) begin
                        for (int i = 0; i < 3; i++) begin
                            ea[i]  <= tri_e[i][144:97];
                            eb[i]  <= tri_e[i][96:49];
                            ec[i]  <= tri_e[i][48:1];
                            etl[i] <= tri_e[i][0];
                        end
                        min_x <= tri_min_x;
                        min_y <= tri_min_y;
                        max_x <= clamp_x;
                        max_y <= clamp_y;
                    end
                end
                INIT: begin
                    for (int i = 0; i < 3; i++) begin
                        e_row[i] <= e_init[i];
                        e_cur[i] <= e_init[i];
                    end
                    cur_x <= min_x;
                    cur_y <= min_y;
                end
                WALK: begin
                    if (advance) begin
                        frag_valid <= covered;
                        if (covered) begin
                            frag_x <= cur_x;
                            frag_y <= cur_y;
                        end
                        if (cur_x < max_x) begin
                            cur_x <= cur_x + 12'd1;
                            for (int i = 0; i < 3; i++) e_cur[i] <= e_cur[i] + ea[i];
                        end else if (cur_y < max_y) begin
                            cur_x <= min_x;
                            cur_y <= cur_y + 12'd1;
                            for (int i = 0; i < 3; i++) begin
                                e_row[i] <= e_row[i] + eb[i];
                                e_cur[i] <= e_row[i] + eb[i];
                            end
                        end
                    end
                end
                DONE: if (frag_valid && frag_ready) frag_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_raster_walker.sv
// Directed bench for raster_walker: a real-valued edge model fills a scoreboard of
// expected fragments, and a negedge monitor pops and compares every accepted fragment.
module tb_raster_walker;
    logic         clk = 1'b0;
    logic         rst;
    logic         tri_valid;
    logic         tri_ready;
    logic [144:0] tri_e0, tri_e1, tri_e2;
    logic [11:0]  tri_min_x, tri_min_y, tri_max_x, tri_max_y;
    logic         tri_en;
    logic         frag_valid;
    logic         frag_ready;
    logic [11:0]  frag_x, frag_y;
    logic         busy;
    logic         tri_done;

    int n_assert = 0;
    int n_fail   = 0;
    int frag_cnt = 0;
    int done_cnt = 0;
    logic [23:0] exp_q [$];

    localparam logic [47:0] ONE  = 48'h000000010000;
    localparam logic [47:0] NEG  = 48'hFFFFFFFF0000;
    localparam logic [47:0] FOUR = 48'h000000040000;
    localparam logic [47:0] ZERO = 48'h0;

    raster_walker dut (
        .clk        (clk),
        .rst        (rst),
        .tri_valid  (tri_valid),
        .tri_ready  (tri_ready),
        .tri_e0     (tri_e0),
        .tri_e1     (tri_e1),
        .tri_e2     (tri_e2),
        .tri_min_x  (tri_min_x),
        .tri_min_y  (tri_min_y),
        .tri_max_x  (tri_max_x),
        .tri_max_y  (tri_max_y),
        .tri_en     (tri_en),
        .frag_valid (frag_valid),
        .frag_ready (frag_ready),
        .frag_x     (frag_x),
        .frag_y     (frag_y),
        .busy       (busy),
        .tri_done   (tri_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [144:0] mk(input logic [47:0] a, input logic [47:0] b,
                                        input logic [47:0] c, input logic tl);
        return {a, b, c, tl};
    endfunction

    function automatic real to_real(input logic [47:0] v);
        return real'(longint'($signed(v))) / 65536.0;
    endfunction

    function automatic bit cov(input logic [144:0] e, input int x, input int y);
        real ev;
        ev = to_real(e[144:97]) * (real'(x) + 0.5) + to_real(e[96:49]) * (real'(y) + 0.5)
             + to_real(e[48:1]);
        return (ev > 0.0) || ((ev == 0.0) && e[0]);
    endfunction

    // Fragment monitor / scoreboard consumer.
    initial begin
        bit stall_prev;
        logic [23:0] prev_xy;
        logic [23:0] want;
        stall_prev = 1'b0;
        prev_xy    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid", 64'(frag_valid), 64'd1);
                    chk("stall_xy", 64'({frag_x, frag_y}), 64'(prev_xy));
                end
                if (frag_valid && frag_ready) begin
                    frag_cnt++;
                    chk("frag_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        want = exp_q.pop_front();
                        chk("frag_xy", 64'({frag_x, frag_y}), 64'(want));
                    end
                end
                stall_prev = frag_valid && !frag_ready;
                prev_xy    = {frag_x, frag_y};
                if (tri_done) done_cnt++;
            end
        end
    end

    task automatic run_tri(input string tag, input logic [144:0] e0, input logic [144:0] e1,
                           input logic [144:0] e2, input int x0, input int y0, input int x1,
                           input int y1, input logic en, input bit bp, input int stop_after,
                           input int exp_cycles, input int exp_first);
        int n, first_n, base, cx1, cy1, n_exp;
        bit seen_done;
        logic r1;
        cx1 = (x1 > 639) ? 639 : x1;
        cy1 = (y1 > 479) ? 479 : y1;
        n_exp = 0;
        if (en)
            for (int y = y0; y <= cy1; y++)
                for (int x = x0; x <= cx1; x++)
                    if (cov(e0, x, y) && cov(e1, x, y) && cov(e2, x, y)) begin
                        exp_q.push_back({12'(x), 12'(y)});
                        n_exp++;
                    end
        base = frag_cnt;
        @(posedge clk); #1;
        tri_e0 = e0; tri_e1 = e1; tri_e2 = e2;
        tri_min_x = 12'(x0); tri_min_y = 12'(y0);
        tri_max_x = 12'(x1); tri_max_y = 12'(y1);
        tri_en = en; tri_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_idle"}, 64'(tri_ready), 64'd1);
        @(posedge clk); #1;
        tri_valid = 1'b0;
        first_n = 0; seen_done = 1'b0; r1 = 1'bx;
        for (n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) r1 = tri_ready;
            if (frag_valid && first_n == 0) first_n = n;
            if (tri_done) begin
                seen_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            frag_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stop_after > 0 && (frag_cnt - base) >= stop_after) break;
        end
        if (stop_after > 0) return;
        chk({tag, "_done_seen"}, 64'(seen_done), 64'd1);
        chk({tag, "_ready_low_after_accept"}, 64'(r1), 64'd0);
        if (exp_cycles > 0) chk({tag, "_cycles"}, 64'(n + 1), 64'(exp_cycles));
        if (exp_first > 0) chk({tag, "_first_latency"}, 64'(first_n - 1), 64'(exp_first));
        @(posedge clk); #1;
        frag_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_after_done"}, 64'(tri_ready), 64'd1);
        chk({tag, "_busy_after_done"}, 64'(busy), 64'd0);
        chk({tag, "_frag_count"}, 64'(frag_cnt - base), 64'(n_exp));
        chk({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [144:0] e0, e1, e2t, e2f, ec;
        int d0;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [144:0] e0, e1, e2t, e2f, ek;
        int d0;
        e0  = mk(ONE, ZERO, ZERO, 1'b0);
        e1  = mk(ZERO, ONE, ZERO, 1'b0);
        e2t = mk(NEG, NEG, FOUR, 1'b1);
        e2f = mk(NEG, NEG, FOUR, 1'b0);
        ek  = mk(ZERO, ZERO, ONE, 1'b0);
        rst = 1'b1; tri_valid = 1'b0; tri_en = 1'b0; frag_ready = 1'b1;
        tri_e0 = '0; tri_e1 = '0; tri_e2 = '0;
        tri_min_x = '0; tri_min_y = '0; tri_max_x = '0; tri_max_y = '0;
        repeat (2) @(negedge clk);
        chk("rst_frag_valid", 64'(frag_valid), 64'd0);
        chk("rst_frag_xy", 64'({frag_x, frag_y}), 64'd0);
        chk("rst_tri_ready", 64'(tri_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tri_done", 64'(tri_done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_tri("basic", e0, e1, e2t, 0, 0, 3, 3, 1'b1, 1'b0, 0, 19, 2);
        run_tri("topleft", e0, e1, e2f, 0, 0, 3, 3, 1'b1, 1'b0, 0, 19, 2);
        run_tri("backpressure", e0, e1, e2t, 0, 0, 3, 3, 1'b1, 1'b1, 0, 0, 0);
        run_tri("degenerate", e0, e1, e2t, 0, 0, 3, 3, 1'b0, 1'b0, 0, 2, 0);
        run_tri("empty_box", e0, e1, e2t, 5, 0, 4, 3, 1'b1, 1'b0, 0, 2, 0);
        run_tri("clamp", ek, ek, ek, 636, 478, 700, 600, 1'b1, 1'b0, 0, 11, 2);

        d0 = done_cnt;
        run_tri("midwalk", e0, e1, e2t, 0, 0, 3, 3, 1'b1, 1'b0, 3, 0, 0);
        rst = 1'b1;
        #1;
        chk("async_rst_frag_valid", 64'(frag_valid), 64'd0);
        chk("async_rst_frag_xy", 64'({frag_x, frag_y}), 64'd0);
        chk("async_rst_tri_ready", 64'(tri_ready), 64'd1);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_tri_done", 64'(tri_done), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("rst_no_tri_done", 64'(done_cnt), 64'(d0));
        @(posedge clk); #1;
        rst = 1'b0;
        run_tri("after_rst", e0, e1, e2t, 0, 0, 3, 3, 1'b1, 1'b0, 0, 19, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
